weight_fetch_scheduler: RTL and testbench
=========================================

WEIGHT_FETCH_SCHEDULER -- requirements
Module: weight_fetch_scheduler

Interface
REQ-001 Parameter: OD_W, 8, width of output-depth count and index.
REQ-002 Parameter: ID_W, 4, width of input-depth count and index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a layer's weight sweep.
REQ-006 total_od_i  input  OD_W  output-depth count for the layer; sampled on accepted start.
REQ-007 total_id_i  input  ID_W  input-depth count for the layer; sampled on accepted start.
REQ-008 pe_ready_i  input  1  downstream PE pair can accept a new weight pair.
REQ-009 weight_valid_i  input  1  weight memory controller's read-complete acknowledge.
REQ-010 weight_main_valid_o  output  1  one-cycle fetch request to the weight memory controller.
REQ-011 weight_od1_o  output  OD_W  first output-depth index of the requested pair.
REQ-012 weight_id_o  output  ID_W  input-depth index of the request.
REQ-013 pair_valid_o  output  1  second slot (od1+1) holds a real output depth.
REQ-014 busy_o  output  1  sweep in progress.
REQ-015 done_o  output  1  one-cycle pulse at end of sweep.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: start_i high SHALL latch totals, clear od/id counters to 0; go ISSUE if both totals nonzero, else DONE.
REQ-018 start_i SHALL be ignored in every state other than IDLE.
REQ-019 ISSUE: weight_main_valid_o SHALL equal pe_ready_i; on pe_ready_i high go WAIT, else stay ISSUE.
REQ-020 weight_od1_o/weight_id_o SHALL present current counters combinationally and hold stable from ISSUE entry until WAIT exit.
REQ-021 WAIT: weight_main_valid_o low; on weight_valid_i high advance counters, otherwise hold.
REQ-022 Advance order: id increments first; at id == total_id-1, id wraps to 0 and od increments by 2.
REQ-023 Advance on last element (id == total_id-1 and od+2 >= total_od) SHALL go DONE; otherwise go ISSUE.
REQ-024 pair_valid_o SHALL be high iff od+1 < total_od (low on final pair of odd total_od).
REQ-025 weight_valid_i outside WAIT SHALL be ignored.
REQ-026 DONE: done_o high for exactly that cycle; next state IDLE.
REQ-027 busy_o SHALL be high in ISSUE and WAIT, low in IDLE and DONE.
REQ-028 od comparisons SHALL use OD_W+1 bits so total_od = 255 does not wrap.
REQ-029 Minimum per-element period SHALL be 2 cycles (ISSUE + WAIT with same-cycle acknowledge).

Reset
REQ-030 reset high SHALL immediately force IDLE, counters and latched totals to 0, all outputs to 0.
REQ-031 reset mid-sweep SHALL abandon the sweep with no done_o pulse.
REQ-032 First start_i honoured SHALL be in the first cycle after reset deasserts.

Configuration
REQ-033 Macro WFS_STALL_CNT_EN defined: extra output stall_cnt_o (16 bits) counts cycles in ISSUE with pe_ready_i low, saturates at 16'hFFFF, clears on accepted start_i and on reset.
REQ-034 WFS_STALL_CNT_EN undefined: stall_cnt_o port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-035 total_od=4, total_id=2, pe_ready_i=1, weight_valid_i acks next cycle -> requests (od,id) = (0,0),(0,1),(2,0),(2,1), pair_valid_o=1 throughout, done_o 8 cycles after start.
REQ-036 total_od=3, total_id=1 -> requests (0,0),(2,0); pair_valid_o=1 then 0; one done_o.
REQ-037 total_od=0, total_id=5 -> no weight_main_valid_o, done_o one cycle after start, busy_o never high.
REQ-038 pe_ready_i low for 5 cycles in ISSUE -> weight_main_valid_o stays 0, indices stable, stall_cnt_o = 5 when WFS_STALL_CNT_EN defined.
REQ-039 reset asserted in WAIT of second element, total_od=8 -> outputs 0 same cycle, no done_o; new start with total_od=2, total_id=1 -> single request (0,0), done_o.
REQ-040 start_i pulsed while busy_o high -> ignored, sweep completes unchanged.

Source files
------------

// File: rtl/weight_fetch_scheduler.sv
// weight_fetch_scheduler
//   Sequences the weight fetches for one layer. A sweep walks the output
//   depth two at a time (a PE pair). For each pair it walks the full input
//   depth. Every (od, id) element is one request to the weight memory
//   controller, followed by a wait for that controller's acknowledge.
//
// Parameters
//   OD_W : width of the output-depth count and index (default 8)
//   ID_W : width of the input-depth count and index  (default 4)
//
// Ports
//   clk                 : clock, rising edge
//   reset               : asynchronous, active-high reset
//   start_i             : begins a sweep; only honoured while idle
//   total_od_i          : output-depth count, latched on accepted start
//   total_id_i          : input-depth count, latched on accepted start
//   pe_ready_i          : the PE pair can take a new weight pair
//   weight_valid_i      : read-complete acknowledge from the memory controller
//   weight_main_valid_o : one-cycle fetch request
//   weight_od1_o        : first output-depth index of the requested pair
//   weight_id_o         : input-depth index of the request
//   pair_valid_o        : second slot (od1+1) is a real output depth
//   busy_o              : a sweep is in progress
//   done_o              : one-cycle pulse at the end of a sweep
//   stall_cnt_o         : (WFS_STALL_CNT_EN only) saturating count of the
//                         ISSUE cycles spent with pe_ready_i low
//
// Build option
//   WFS_STALL_CNT_EN : adds the stall_cnt_o port and its counter.
module weight_fetch_scheduler #(
  parameter int unsigned OD_W = 8,
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [OD_W-1:0] total_od_i,
  input  logic [ID_W-1:0] total_id_i,
  input  logic            pe_ready_i,
  input  logic            weight_valid_i,
  output logic            weight_main_valid_o,
  output logic [OD_W-1:0] weight_od1_o,
  output logic [ID_W-1:0] weight_id_o,
  output logic            pair_valid_o,
  output logic            busy_o,
  output logic            done_o
`ifdef WFS_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_d;
  logic [OD_W-1:0] od_q, od_d, tot_od_q, tot_od_d;
  logic [ID_W-1:0] id_q, id_d, tot_id_q, tot_id_d;

  // The od arithmetic is one bit wider than the count, so od+2 cannot wrap
  // when total_od is at its maximum value.
  logic [OD_W:0]   od_plus1, od_plus2;
  logic [ID_W:0]   id_plus1;
  logic            id_last, od_last;

  assign od_plus1 = {1'b0, od_q} + (OD_W+1)'(1);
  assign od_plus2 = {1'b0, od_q} + (OD_W+1)'(2);
  assign id_plus1 = {1'b0, id_q} + (ID_W+1)'(1);
  assign id_last  = (id_plus1 == {1'b0, tot_id_q});
  assign od_last  = (od_plus2 >= {1'b0, tot_od_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      od_q     <= '0;
      id_q     <= '0;
      tot_od_q <= '0;
      tot_id_q <= '0;
    end else begin
      state_q  <= state_d;
      od_q     <= od_d;
      id_q     <= id_d;
      tot_od_q <= tot_od_d;
      tot_id_q <= tot_id_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    od_d                = od_q;
    id_d                = id_q;
    tot_od_d            = tot_od_q;
    tot_id_d            = tot_id_q;
    weight_main_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          tot_od_d = total_od_i;
          tot_id_d = total_id_i;
          od_d     = '0;
          id_d     = '0;
          state_d  = (total_od_i != '0 && total_id_i != '0) ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        weight_main_valid_o = pe_ready_i;
        if (pe_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (weight_valid_i) begin
          // The final element leaves the counters on the last pair, so the
          // indices never pass total_od.
          if (id_last && od_last) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            if (id_last) begin
              id_d = '0;
              od_d = od_plus2[OD_W-1:0];
            end else begin
              id_d = id_plus1[ID_W-1:0];
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign weight_od1_o = od_q;
  assign weight_id_o  = id_q;
  assign pair_valid_o = (od_plus1 < {1'b0, tot_od_q});
  assign busy_o       = (state_q == ISSUE) || (state_q == WAIT);
  assign done_o       = (state_q == DONE);

`ifdef WFS_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == IDLE && start_i) begin
      stall_q <= '0;
    end else if (state_q == ISSUE && !pe_ready_i && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
module tb_weight_fetch_scheduler;
  localparam int unsigned OD_W = 8;
  localparam int unsigned ID_W = 4;
  localparam int PH_ISSUE = 0;
  localparam int PH_WAIT  = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            start_i;
  logic [OD_W-1:0] total_od_i;
  logic [ID_W-1:0] total_id_i;
  logic            pe_ready_i;
  logic            weight_valid_i;
  logic            weight_main_valid_o;
  logic [OD_W-1:0] weight_od1_o;
  logic [ID_W-1:0] weight_id_o;
  logic            pair_valid_o;
  logic            busy_o;
  logic            done_o;
`ifdef WFS_STALL_CNT_EN
  logic [15:0]     stall_cnt_o;
`endif

  weight_fetch_scheduler #(.OD_W(OD_W), .ID_W(ID_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start_i),
    .total_od_i          (total_od_i),
    .total_id_i          (total_id_i),
    .pe_ready_i          (pe_ready_i),
    .weight_valid_i      (weight_valid_i),
    .weight_main_valid_o (weight_main_valid_o),
    .weight_od1_o        (weight_od1_o),
    .weight_id_o         (weight_id_o),
    .pair_valid_o        (pair_valid_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
`ifdef WFS_STALL_CNT_EN
    ,
    .stall_cnt_o         (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // One sweep: totals, pe_ready_i low cycles before each request, cycles
  // of ack delay in WAIT, a stray start_i while busy, weight_valid_i driven
  // during stalls, expected edges from start to done_o, expected stall count.
  typedef struct {
    int tot_od;
    int tot_id;
    int stall;
    int ack;
    bit poke;
    bit noisy;
    int exp_lat;
    int exp_stall;
  } vec_t;

  typedef struct {
    int od;
    int id;
    bit pair;
  } req_t;

  req_t q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v);
    int   n = 0;
    int   lat = -1;
    int   phase = PH_ISSUE;
    int   stall_left = v.stall;
    int   ack_left = 0;
    bit   busy_seen = 1'b0;
    req_t r;

    if (v.tot_od > 0 && v.tot_id > 0) begin
      for (int od = 0; od < v.tot_od; od += 2) begin
        for (int id = 0; id < v.tot_id; id++) begin
          r.od = od; r.id = id; r.pair = (od + 1 < v.tot_od);
          q.push_back(r);
          n++;
        end
      end
    end

    total_od_i     = OD_W'(v.tot_od);
    total_id_i     = ID_W'(v.tot_id);
    start_i        = 1'b1;
    pe_ready_i     = 1'b0;
    weight_valid_i = 1'b0;
    @(posedge clk);

    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start_i        = (v.poke && k == 1);
      total_od_i     = 8'hA5;
      total_id_i     = 4'h3;
      pe_ready_i     = 1'b0;
      weight_valid_i = 1'b0;
      if (phase == PH_ISSUE) begin
        if (stall_left > 0) weight_valid_i = v.noisy;
        else                pe_ready_i = 1'b1;
      end else if (ack_left == 0) begin
        weight_valid_i = 1'b1;
      end
      #1;
      if (busy_o) busy_seen = 1'b1;
      if (done_o) begin
        lat = k;
        check("busy_at_done", busy_o, 0);
        break;
      end
      if (phase == PH_ISSUE && stall_left > 0) begin
        check("stall_valid", weight_main_valid_o, 0);
        if (q.size() > 0) begin
          check("stall_od", weight_od1_o, q[0].od);
          check("stall_id", weight_id_o, q[0].id);
        end
        stall_left--;
      end else if (phase == PH_ISSUE) begin
        check("issue_valid", weight_main_valid_o, 1);
        if (weight_main_valid_o) begin
          if (q.size() == 0) begin
            check("extra_req", 1, 0);
          end else begin
            r = q.pop_front();
            check("req_od", weight_od1_o, r.od);
            check("req_id", weight_id_o, r.id);
            check("req_pair", pair_valid_o, r.pair);
          end
        end
        phase    = PH_WAIT;
        ack_left = v.ack;
      end else begin
        check("wait_valid", weight_main_valid_o, 0);
        if (ack_left == 0) begin
          phase      = PH_ISSUE;
          stall_left = v.stall;
        end else begin
          ack_left--;
        end
      end
    end

    check("done_latency", lat, v.exp_lat);
    check("reqs_left", q.size(), 0);
    check("busy_seen", busy_seen, (n > 0));
    q.delete();
`ifdef WFS_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, v.exp_stall);
`endif

    @(negedge clk);
    start_i        = 1'b0;
    pe_ready_i     = 1'b0;
    weight_valid_i = 1'b0;
    #1;
    check("done_pulse_end", done_o, 0);
    check("idle_busy", busy_o, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, weight_main_valid_o, 0);
    check({tag, "_od1"}, weight_od1_o, 0);
    check({tag, "_id"}, weight_id_o, 0);
    check({tag, "_pair"}, pair_valid_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
`ifdef WFS_STALL_CNT_EN
    check({tag, "_stall"}, stall_cnt_o, 0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           od   id  stl ack poke noisy lat stall
    vecs[0] = '{   4,  2,  0,  0, 0, 0,   8, 0};
    vecs[1] = '{   3,  1,  0,  0, 0, 0,   4, 0};
    vecs[2] = '{   0,  5,  0,  0, 0, 0,   0, 0};
    vecs[3] = '{   5,  0,  0,  0, 0, 0,   0, 0};
    vecs[4] = '{   1,  3,  0,  1, 0, 0,   9, 0};
    vecs[5] = '{   8,  2,  0,  2, 0, 0,  32, 0};
    vecs[6] = '{   2,  1,  5,  0, 0, 1,   7, 5};
    vecs[7] = '{ 255,  1,  0,  0, 0, 0, 256, 0};
    vecs[8] = '{   6,  3,  0,  0, 1, 0,  18, 0};
    vecs[9] = '{   2, 15,  0,  0, 0, 0,  30, 0};

    reset          = 1'b1;
    start_i        = 1'b0;
    total_od_i     = '0;
    total_id_i     = '0;
    pe_ready_i     = 1'b0;
    weight_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the WAIT of the second element of an 8x2 sweep.
    total_od_i     = 8'd8;
    total_id_i     = 4'd2;
    start_i        = 1'b1;
    pe_ready_i     = 1'b1;
    weight_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    pe_ready_i     = 1'b0;
    weight_valid_i = 1'b1;
    @(negedge clk);
    pe_ready_i     = 1'b1;
    weight_valid_i = 1'b0;
    #1;
    check("mid_valid", weight_main_valid_o, 1);
    check("mid_id", weight_id_o, 1);
    @(negedge clk);
    pe_ready_i = 1'b0;
    #1;
    check("mid_busy", busy_o, 1);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    #1;
    check("midreset_no_done", done_o, 0);
    reset = 1'b0;
    run_vec('{2, 1, 0, 0, 0, 0, 2, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
